// File: rtl/filt_pkg.sv
// Shared constants and types for the IIR inverse filter: default sample width,
// saturation bounds and the signed intermediate used for the difference.
package filt_pkg;

    localparam int unsigned FILT_W = 4;

    localparam int SAT_LO = 0;
    localparam int SAT_HI = (1 << FILT_W) - 1;

    typedef logic signed [FILT_W+1:0] filt_diff_t;

    function automatic int sat_hi(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/iir_inv_datapath.sv
// Combinational deconvolution step: d = 2*y - floor(y_1/2), clamped to [0, 2^W-1].
// Also reports whether the clamp was applied.
module iir_inv_datapath
    import filt_pkg::*;
#(
    parameter int unsigned W = FILT_W
) (
    input  logic [W-1:0] y,
    input  logic [W-1:0] y_1,
    output logic [W-1:0] x,
    output logic         clamp
);

    localparam logic signed [W+1:0] L_LO = (W+2)'(SAT_LO);
    localparam logic signed [W+1:0] L_HI = (W+2)'(sat_hi(W));

    logic [W+1:0]        w_two_y;
    logic [W+1:0]        w_half_y_1;
    logic signed [W+1:0] w_d;

    // W+2 bits holds both 2*(2^W-1) and -(2^(W-1)-1) without overflow.
    assign w_two_y    = {1'b0, y, 1'b0};
    assign w_half_y_1 = {3'b000, y_1[W-1:1]};
    assign w_d        = $signed(w_two_y) - $signed(w_half_y_1);

    always_comb begin
        x     = w_d[W-1:0];
        clamp = 1'b0;
        if (w_d < L_LO) begin
            x     = L_LO[W-1:0];
            clamp = 1'b1;
        end else if (w_d > L_HI) begin
            x     = L_HI[W-1:0];
            clamp = 1'b1;
        end
    end

endmodule

// File: rtl/iir_inverse_filter.sv
// Inverse of y[n] = 0.25*y[n-1] + 0.5*x[n] behind a 2-stage valid/ready pipeline.
// Optional saturation counter port sat_cnt is enabled by IIR_INV_SAT_COUNT_EN.
module iir_inverse_filter
    import filt_pkg::*;
#(
    parameter int unsigned W = FILT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] y_in,
    input  logic         y_is_valid,
    output logic         y_ready,
    input  logic         hist_clr,
    output logic [W-1:0] x_out,
    output logic         x_is_valid,
    input  logic         x_ready
`ifdef IIR_INV_SAT_COUNT_EN
    ,
    output logic [7:0]   sat_cnt
`endif
);

    logic [W-1:0] r_y_1;
    logic [W-1:0] r_s1_y;
    logic [W-1:0] r_s1_y_1;
    logic         r_s1_valid;
    logic [W-1:0] r_s2_x;
    logic         r_s2_valid;

    logic         w_adv2;
    logic         w_adv1;
    logic         w_accept;
    logic [W-1:0] w_y_1_eff;
    logic [W-1:0] w_x;
    logic         w_clamp;

    assign w_adv2     = !r_s2_valid || x_ready;
    assign w_adv1     = w_adv2;
    assign y_ready    = !r_s1_valid || w_adv1;
    assign w_accept   = y_is_valid && y_ready;
    // A clear coinciding with an accept applies to that very sample.
    assign w_y_1_eff  = hist_clr ? '0 : r_y_1;
    assign x_out      = r_s2_x;
    assign x_is_valid = r_s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_1 <= '0;
        end else if (w_accept) begin
            r_y_1 <= y_in;
        end else if (hist_clr) begin
            r_y_1 <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (y_ready) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_y   <= y_in;
                r_s1_y_1 <= w_y_1_eff;
            end
        end
    end

    iir_inv_datapath #(
        .W (W)
    ) u_datapath (
        .y     (r_s1_y),
        .y_1   (r_s1_y_1),
        .x     (w_x),
        .clamp (w_clamp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_x     <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_x <= w_x;
            end
        end
    end

`ifdef IIR_INV_SAT_COUNT_EN
    logic       r_s2_clamp;
    logic [7:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_clamp <= 1'b0;
        end else if (w_adv2 && r_s1_valid) begin
            r_s2_clamp <= w_clamp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (r_s2_valid && x_ready && r_s2_clamp && (r_sat_cnt != 8'hFF)) begin
            r_sat_cnt <= r_sat_cnt + 8'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`else
    logic w_clamp_unused;
    assign w_clamp_unused = w_clamp;
`endif

endmodule

// File: doc/iir_inverse_filter.md
Name: iir_inverse_filter

Overview:
- Inverse (deconvolution) block for the first-order IIR stage y[n] = 0.25*y[n-1] + 0.5*x[n].
- Takes a stream of filtered samples y, reconstructs the estimate x_hat[n] = 2*y[n] - floor(y[n-1]/2), saturates it, and delivers it through a 2-stage valid/ready pipeline.
- Sits at the receive end of the filter chain. Inputs are recovered from logged or transmitted filter outputs.

Parameters:
- W, 4, sample width in bits for y_in and x_out; unsigned integer samples.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- y_in  in  W  filtered sample.
- y_is_valid  in  1  y_in valid.
- y_ready  out  1  block can accept y_in this cycle.
- hist_clr  in  1  zero the history register y_1 (single-cycle pulse).
- x_out  out  W  reconstructed sample.
- x_is_valid  out  1  x_out valid.
- x_ready  in  1  downstream accepts x_out.

Behaviour:
- Reset: clk and rst only; rst sampled on rising edge. Clears y_1=0, s1_valid=0, s2_valid=0, x_out=0, x_is_valid=0. y_ready is 1 in the cycle after reset.
- Handshakes:
  - Input is accepted when y_is_valid && y_ready.
  - Output transfers when x_is_valid && x_ready.
  - x_out and x_is_valid are held stable while x_is_valid && !x_ready.
- Pipeline:
  - Stage 1 registers {y, y_1}.
  - Stage 2 registers the saturated result.
  - adv2 = !s2_valid || x_ready.
  - adv1 = adv2.
  - y_ready = !s1_valid || adv1, combinational.
- Latency: accepted sample appears on x_out 2 cycles later when unstalled. Throughput is 1 sample/cycle.
- History: y_1 <= y_in on each accepted input.
  - The first sample after rst or hist_clr uses y_1=0.
  - hist_clr with no accept: y_1 <= 0.
  - hist_clr with a simultaneous accept: the accepted sample uses y_1=0, then y_1 <= y_in.
  - hist_clr does not flush samples already in the pipeline.
- Arithmetic:
  - Signed, W+2 bits: d = (y<<1) - (y_1>>1).
  - If d<0, x_out=0.
  - If d>2^W-1, x_out=2^W-1.
  - Otherwise x_out=d[W-1:0].
- Stall: when s2 is full and x_ready=0, s1 holds. y_ready=0 once s1 is also full. No sample is lost or duplicated.
- Reset mid-stream: in-flight samples are discarded and nothing is emitted. History is cleared.
- No state machine beyond the two valid bits. The valid pair (s1,s2) walks EMPTY → ONE → FULL and back as traffic flows.

Optional Feature:
- Macro: IIR_INV_SAT_COUNT_EN.
- Defined:
  - Adds output port sat_cnt [7:0].
  - It increments on each output transfer whose value was clamped, in either direction.
  - It holds at 255 and is cleared by rst.
  - The clamp flag travels through stage 2 with its sample.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package filt_pkg holds:
  - default width constant FILT_W=4;
  - the saturation bounds;
  - a typedef for the W+2 signed intermediate.
- One sub-module, iir_inv_datapath: combinational difference and saturation computing x and the clamp flag. The top module owns the history register, the pipeline registers and the handshake.

Test Plan:
1. Reset, then y_in = 4,6,2 on consecutive cycles with x_ready=1 -> x_out = 8,10,1. Each appears 2 cycles after its accept; no gaps.
2. y_in=9 after 2, then y_in=0 -> x_out=15 (clamped high; d=17), then 0 (clamped low; d=-4). With IIR_INV_SAT_COUNT_EN, sat_cnt=2.
3. Fill the pipeline with 4,6,2 while x_ready=0 -> y_ready drops after 2 accepts and x_out=8 is held stable. Release x_ready -> 8,10,1 emitted in order, no loss or duplicates.
4. After y=6, pulse hist_clr alone, then y_in=4 -> x_out=8. Repeat with hist_clr coincident with the y_in=4 accept -> x_out=8, and the next y_in=4 gives 6.
5. Assert rst while 2 samples are in flight -> x_is_valid=0 next cycle, nothing emitted. First post-reset y_in=3 -> x_out=6.
6. Random valid/ready toggling over 1000 samples -> output sequence matches the reference model exactly.
